// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle for rr_decode_arbiter: master drives requests and
// release, slave (the arbiter) returns the registered grant.
interface rr_decode_arbiter_if;
  logic [0:3] req;
  logic       rel;
  logic [0:3] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  tmo
  );

  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output tmo
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 4 requesters with one-hot grant (idx0 -> 4'b1000)
// and a dead cycle after every grant. Define ARB_TIMEOUT_EN for forced release.
module rr_decode_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_decode_arbiter_if.slave  bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] idx_q;
  logic [0:3] gnt_q;
  logic       vld_q;

  logic [1:0] win_d;
  logic [1:0] cand_d;
  logic       any_req_d;
  logic       release_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  logic [CntW-1:0] cnt_q;
  logic            tmo_q;
`endif

  // Scan from the far end back toward ptr so the nearest requester wins last.
  always_comb begin
    win_d     = 2'b00;
    cand_d    = 2'b00;
    any_req_d = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand_d = ptr_q + 2'(i);
      if (bus.req[cand_d]) begin
        win_d     = cand_d;
        any_req_d = 1'b1;
      end
    end
  end

  assign release_d = bus.rel | ~bus.req[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'b00;
      idx_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle, StGap: begin
          if (any_req_d) begin
            state_q <= StGrant;
            gnt_q   <= 4'b1000 >> win_d;
            idx_q   <= win_d;
            vld_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            vld_q   <= 1'b0;
          end
        end
        StGrant: begin
          if (release_d) begin
            state_q <= StGap;
            gnt_q   <= 4'b0000;
            vld_q   <= 1'b0;
            ptr_q   <= idx_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
          end else if (cnt_q == CntW'(HOLD_MAX - 1)) begin
            // Grant has now lasted HOLD_MAX cycles: force it off like a release.
            state_q <= StGap;
            gnt_q   <= 4'b0000;
            vld_q   <= 1'b0;
            ptr_q   <= idx_q + 2'd1;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 4'b0000;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.tmo     = tmo_q;
`else
  assign bus.tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed-vector bench for rr_decode_arbiter; expected grants are hand-derived
// from the round-robin pointer sequence.
module tb_rr_decode_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(
    .HOLD_MAX (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_gnt(input string tag, input logic [3:0] gnt, input logic [1:0] idx,
                           input logic vld);
    check_eq({tag, ".gnt"}, 32'(bus.gnt), 32'(gnt));
    check_eq({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    check_eq({tag, ".vld"}, 32'(bus.gnt_vld), 32'(vld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [5];
  logic [1:0] rr_idx [5];
  int         n_hi;
  int         tmo_cnt;
  logic       dropped;
  logic       tmo_at_drop;
  logic       tmo_after;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.rel = 1'b0;
    #12;
    check_gnt("reset", 4'b0000, 2'b00, 1'b0);
    check_eq("reset.tmo", 32'(bus.tmo), 32'd0);
    rst_n = 1'b1;
    tick();

    // Advance ptr to 3, re-grant requester 2, then reset mid-grant.
    bus.req = 4'b0010;
    tick();
    check_gnt("t1.first", 4'b0010, 2'b10, 1'b1);
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    tick();
    check_gnt("t1.regrant", 4'b0010, 2'b10, 1'b1);
    rst_n = 1'b0;
    #2;
    check_gnt("t1.async", 4'b0000, 2'b00, 1'b0);
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    tick();
    check_gnt("t1.ptr0", 4'b1000, 2'b00, 1'b1);

    // Single requester with a release pulse and a GAP cycle.
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    bus.req = 4'b0010;
    tick();
    check_gnt("t2.grant", 4'b0010, 2'b10, 1'b1);
    bus.rel = 1'b1;
    tick();
    check_gnt("t2.gap", 4'b0000, 2'b10, 1'b0);
    bus.rel = 1'b0;
    tick();
    check_gnt("t2.again", 4'b0010, 2'b10, 1'b1);

    // Round robin from ptr=0 with all requesting.
    rst_n = 1'b0;
    #2;
    rst_n   = 1'b1;
    bus.rel = 1'b0;
    bus.req = 4'b1111;
    rr_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    rr_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      tick();
      check_gnt($sformatf("t3.g%0d", k), rr_exp[k], rr_idx[k], 1'b1);
      tick();
      check_eq($sformatf("t3.hold%0d", k), 32'(bus.gnt), 32'(rr_exp[k]));
      bus.rel = 1'b1;
      tick();
      check_eq($sformatf("t3.gap%0d", k), 32'(bus.gnt), 32'd0);
      bus.rel = 1'b0;
    end

    // Wrap/skip: get ptr to 3, then 3 -> 0.
    bus.req = 4'b0010;
    tick();
    check_gnt("t4.setup", 4'b0010, 2'b10, 1'b1);
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
    bus.req = 4'b0101;
    tick();
    check_gnt("t4.skip", 4'b0001, 2'b11, 1'b1);
    bus.rel = 1'b1;
    bus.req = 4'b1010;
    tick();
    check_gnt("t4.gap", 4'b0000, 2'b11, 1'b0);
    bus.rel = 1'b0;
    tick();
    check_gnt("t4.wrap", 4'b1000, 2'b00, 1'b1);

    // Implicit release and no pre-emption.
    bus.rel = 1'b1;
    bus.req = 4'b0100;
    tick();
    bus.rel = 1'b0;
    tick();
    check_gnt("t5.grant", 4'b0100, 2'b01, 1'b1);
    bus.req = 4'b1100;
    tick();
    check_gnt("t5.nopreempt", 4'b0100, 2'b01, 1'b1);
    bus.req = 4'b1000;
    tick();
    check_gnt("t5.implicit", 4'b0000, 2'b01, 1'b0);
    bus.req = 4'b1001;
    tick();
    check_gnt("t5.ptr2", 4'b0001, 2'b11, 1'b1);
    bus.req = 4'b0000;
    tick();
    tick();
    check_gnt("t5.idle", 4'b0000, 2'b11, 1'b0);

    // Long hold with no release.
    bus.req     = 4'b1000;
    n_hi        = 0;
    tmo_cnt     = 0;
    dropped     = 1'b0;
    tmo_at_drop = 1'b0;
    tmo_after   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!dropped) begin
        if (bus.gnt == 4'b1000) n_hi++;
        else begin
          dropped     = 1'b1;
          tmo_at_drop = bus.tmo;
          tick();
          tmo_after   = bus.tmo;
        end
      end
      if (bus.tmo) tmo_cnt++;
    end
`ifdef ARB_TIMEOUT_EN
    check_eq("t6.hold_cycles", 32'(n_hi), 32'd8);
    check_eq("t6.tmo_drop", 32'(tmo_at_drop), 32'd1);
    check_eq("t6.tmo_pulse", 32'(tmo_after), 32'd0);
`else
    check_eq("t6.hold_cycles", 32'(n_hi), 32'd100);
    check_eq("t6.tmo_never", 32'(tmo_cnt), 32'd0);
    check_eq("t6.dropped", 32'(dropped), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
